fir_stream_controller: RTL and testbench



---
 rtl/fir_ctrl_pkg.sv | 28 ++
 rtl/fir_out_fifo.sv | 71 +++++++
 rtl/fir_stream_controller.sv | 193 +++++++++++++++++++
 tb/tb_fir_stream_controller.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_ctrl_pkg
//  Purpose  : Shared types and helpers for the FIR stream controller.
//             Provides the controller state encoding, the common data width
//             and the tap-count legality check.
//  Revision : 1.0  initial release
// ============================================================================
package fir_ctrl_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_CLEAR      = 3'd1,
      ST_LOAD_COEFF = 3'd2,
      ST_RUN        = 3'd3,
      ST_DRAIN      = 3'd4
   } fir_ctrl_state_e;

   // A tap count is usable when it lies in 1..max_taps.
   function automatic logic tap_count_legal(input logic [DATA_W-1:0] tap_count,
                                            input logic [DATA_W-1:0] max_taps);
      return (tap_count != '0) && (tap_count <= max_taps);
   endfunction

endpackage : fir_ctrl_pkg
`default_nettype wire

// File: rtl/fir_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fir_out_fifo
//  Purpose  : Synchronous result FIFO with occupancy count. The head entry is
//             presented directly on pop_data, so it stays stable until popped.
//  Ports    : clk, rstn        clock, asynchronous active-low reset
//             push, push_data  write request and data (ignored when full)
//             pop              read request (ignored when empty)
//             pop_data         head entry
//             empty            no entries stored
//             count            number of entries stored (0..DEPTH)
//  Revision : 1.0  initial release
// ============================================================================
module fir_out_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_do_push = push && !w_full;
   assign w_do_pop  = pop && !empty;
   assign pop_data  = r_mem[r_rd_ptr];
   assign count     = r_count;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : fir_out_fifo
`default_nettype wire

// File: rtl/fir_stream_controller.sv
`default_nettype none
// ============================================================================
//  Module   : fir_stream_controller
//  Purpose  : Sequencing and flow-control front end for the FIR datapath.
//             Loads tap_count coefficients after clearing the datapath, then
//             streams samples in and buffers results so that downstream
//             backpressure never loses a datapath result.
//  Ports    : clk, rstn                 clock, asynchronous active-low reset
//             cfg_start/stop/tap_count  run control; cfg_error sticky error
//             busy                      controller not idle
//             s_coeff_*                 coefficient stream (AXI-S style)
//             s_data_*                  sample stream (AXI-S style)
//             m_data_*                  result stream (AXI-S style)
//             dp_*                      datapath control, writes and result
//  Revision : 1.0  initial release
// ============================================================================
module fir_stream_controller
   import fir_ctrl_pkg::*;
#(
   parameter int MAX_TAPS       = 16,
   parameter int OUT_FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cfg_start,
   input  logic              cfg_stop,
   input  logic [DATA_W-1:0] cfg_tap_count,
   output logic              busy,
   output logic              cfg_error,
   input  logic              s_coeff_tvalid,
   output logic              s_coeff_tready,
   input  logic [DATA_W-1:0] s_coeff_tdata,
   input  logic              s_data_tvalid,
   output logic              s_data_tready,
   input  logic [DATA_W-1:0] s_data_tdata,
   output logic              m_data_tvalid,
   input  logic              m_data_tready,
   output logic [DATA_W-1:0] m_data_tdata,
   output logic              dp_rstn,
   output logic [DATA_W-1:0] dp_tap_count,
   output logic              dp_coeff_data_valid,
   output logic [DATA_W-1:0] dp_coeff_data,
   output logic              dp_input_data_valid,
   output logic [DATA_W-1:0] dp_input_data,
   output logic              dp_compute,
   input  logic              dp_output_data_valid,
   input  logic [DATA_W-1:0] dp_output_data
);

   localparam int CNT_W  = $clog2(MAX_TAPS + 1);
   localparam int FCNT_W = $clog2(OUT_FIFO_DEPTH) + 1;
   localparam logic [FCNT_W:0] C_FIFO_DEPTH = (FCNT_W+1)'(OUT_FIFO_DEPTH);

   fir_ctrl_state_e   r_state;
   fir_ctrl_state_e   w_state_nxt;
   logic [CNT_W-1:0]  r_coeff_cnt;
   logic              r_busy;
   logic              r_cfg_error;
   logic              r_coeff_ready;
   logic              r_dp_rstn;
   logic              r_dp_compute;
   logic [DATA_W-1:0] r_tap_count;
   logic              r_coeff_valid;
   logic [DATA_W-1:0] r_coeff_data;
   logic              r_in_valid;      // sample on dp_input_data this cycle
   logic [DATA_W-1:0] r_in_data;
   logic              r_result_slot;   // datapath result cycle for that sample

   logic              w_start_legal;
   logic              w_coeff_hs;
   logic              w_last_coeff;
   logic              w_data_hs;
   logic [FCNT_W:0]   w_occupancy;
   logic [FCNT_W-1:0] w_fifo_count;
   logic              w_fifo_empty;
   logic              w_fifo_pop;

   assign w_start_legal = tap_count_legal(cfg_tap_count, DATA_W'(MAX_TAPS));
   assign w_coeff_hs    = r_coeff_ready && s_coeff_tvalid;
   assign w_last_coeff  = ((r_coeff_cnt + CNT_W'(1)) == r_tap_count[CNT_W-1:0]);

   // Credits: every accepted sample holds a slot until its result cycle has
   // passed, whether or not that result is valid. Counting both pipeline
   // stages against the FIFO room guarantees a push never meets a full FIFO.
   assign w_occupancy = {1'b0, w_fifo_count}
                      + (FCNT_W+1)'(r_in_valid)
                      + (FCNT_W+1)'(r_result_slot);
   assign s_data_tready = (r_state == ST_RUN) && (w_occupancy < C_FIFO_DEPTH);
   assign w_data_hs     = s_data_tready && s_data_tvalid;

   assign w_fifo_pop    = m_data_tready && !w_fifo_empty;
   assign m_data_tvalid = !w_fifo_empty;

   assign busy                = r_busy;
   assign cfg_error           = r_cfg_error;
   assign s_coeff_tready      = r_coeff_ready;
   assign dp_rstn             = r_dp_rstn;
   assign dp_compute          = r_dp_compute;
   assign dp_tap_count        = r_tap_count;
   assign dp_coeff_data_valid = r_coeff_valid;
   assign dp_coeff_data       = r_coeff_data;
   assign dp_input_data_valid = r_in_valid;
   assign dp_input_data       = r_in_data;

   // A stop arriving together with a handshake lets the handshake complete
   // (the write logic below is independent of the transition).
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:       if (cfg_start && w_start_legal) w_state_nxt = ST_CLEAR;
         ST_CLEAR:      w_state_nxt = ST_LOAD_COEFF;
         ST_LOAD_COEFF: begin
            if (cfg_stop)                        w_state_nxt = ST_IDLE;
            else if (w_coeff_hs && w_last_coeff) w_state_nxt = ST_RUN;
         end
         ST_RUN:        if (cfg_stop) w_state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (w_fifo_empty && !r_in_valid && !r_result_slot) w_state_nxt = ST_IDLE;
         end
         default:       w_state_nxt = ST_IDLE;
      endcase
   end

   // State register plus outputs registered from the next state, so every
   // control output changes in the same cycle as the state it belongs to.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state       <= ST_IDLE;
         r_busy        <= 1'b0;
         r_cfg_error   <= 1'b0;
         r_coeff_ready <= 1'b0;
         r_dp_rstn     <= 1'b0;
         r_dp_compute  <= 1'b0;
         r_tap_count   <= '0;
         r_coeff_cnt   <= '0;
         r_coeff_valid <= 1'b0;
         r_coeff_data  <= '0;
         r_in_valid    <= 1'b0;
         r_in_data     <= '0;
         r_result_slot <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_busy        <= (w_state_nxt != ST_IDLE);
         r_coeff_ready <= (w_state_nxt == ST_LOAD_COEFF);
         r_dp_rstn     <= (w_state_nxt != ST_CLEAR);
         // Compute stays enabled while draining so in-flight samples still
         // produce their results.
         r_dp_compute  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);

         if ((r_state == ST_IDLE) && cfg_start) begin
            if (w_start_legal) begin
               r_tap_count <= cfg_tap_count;
               r_cfg_error <= 1'b0;
            end else begin
               r_cfg_error <= 1'b1;
            end
         end

         if (r_state == ST_CLEAR) begin
            r_coeff_cnt <= '0;
         end else if (w_coeff_hs) begin
            r_coeff_cnt <= r_coeff_cnt + CNT_W'(1);
         end

         r_coeff_valid <= w_coeff_hs;
         if (w_coeff_hs) begin
            r_coeff_data <= s_coeff_tdata;
         end

         r_in_valid    <= w_data_hs;
         r_result_slot <= r_in_valid;
         if (w_data_hs) begin
            r_in_data <= s_data_tdata;
         end
      end
   end

   fir_out_fifo #(
      .DEPTH (OUT_FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_out_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (dp_output_data_valid),
      .push_data (dp_output_data),
      .pop       (w_fifo_pop),
      .pop_data  (m_data_tdata),
      .empty     (w_fifo_empty),
      .count     (w_fifo_count)
   );

endmodule : fir_stream_controller
`default_nettype wire

// File: tb/tb_fir_stream_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_stream_controller
//  Purpose  : Directed self-checking bench for fir_stream_controller, with a
//             small datapath model (result = 3*sample + 7, optional warm-up).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_stream_controller;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cfg_start, cfg_stop;
   logic [31:0] cfg_tap_count;
   logic        busy, cfg_error;
   logic        s_coeff_tvalid, s_coeff_tready;
   logic [31:0] s_coeff_tdata;
   logic        s_data_tvalid, s_data_tready;
   logic [31:0] s_data_tdata;
   logic        m_data_tvalid, m_data_tready;
   logic [31:0] m_data_tdata;
   logic        dp_rstn;
   logic [31:0] dp_tap_count;
   logic        dp_coeff_data_valid;
   logic [31:0] dp_coeff_data;
   logic        dp_input_data_valid;
   logic [31:0] dp_input_data;
   logic        dp_compute;
   logic        dp_out_v;
   logic [31:0] dp_out_d;

   int n_vec = 0;
   int n_miscompare = 0;
   int warm;
   int dp_seen;

   always #5 clk = ~clk;

   fir_stream_controller #(
      .MAX_TAPS       (16),
      .OUT_FIFO_DEPTH (4)
   ) dut (
      .clk                  (clk),
      .rstn                 (rstn),
      .cfg_start            (cfg_start),
      .cfg_stop             (cfg_stop),
      .cfg_tap_count        (cfg_tap_count),
      .busy                 (busy),
      .cfg_error            (cfg_error),
      .s_coeff_tvalid       (s_coeff_tvalid),
      .s_coeff_tready       (s_coeff_tready),
      .s_coeff_tdata        (s_coeff_tdata),
      .s_data_tvalid        (s_data_tvalid),
      .s_data_tready        (s_data_tready),
      .s_data_tdata         (s_data_tdata),
      .m_data_tvalid        (m_data_tvalid),
      .m_data_tready        (m_data_tready),
      .m_data_tdata         (m_data_tdata),
      .dp_rstn              (dp_rstn),
      .dp_tap_count         (dp_tap_count),
      .dp_coeff_data_valid  (dp_coeff_data_valid),
      .dp_coeff_data        (dp_coeff_data),
      .dp_input_data_valid  (dp_input_data_valid),
      .dp_input_data        (dp_input_data),
      .dp_compute           (dp_compute),
      .dp_output_data_valid (dp_out_v),
      .dp_output_data       (dp_out_d)
   );

   // Datapath model: result one cycle after the input write; the first
   // `warm` samples after a datapath reset give warm-up (invalid) results.
   always_ff @(posedge clk) begin
      if (!dp_rstn) begin
         dp_out_v <= 1'b0;
         dp_out_d <= '0;
         dp_seen  <= 0;
      end else begin
         dp_out_v <= dp_input_data_valid && (dp_seen >= warm);
         dp_out_d <= dp_input_data * 32'd3 + 32'd7;
         if (dp_input_data_valid) dp_seen <= dp_seen + 1;
      end
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscompare++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_run(input logic [31:0] taps);
      cfg_tap_count = taps;
      cfg_start     = 1'b1;
      tick();
      cfg_start     = 1'b0;
   endtask

   // Called in the CLEAR cycle; returns in the first RUN cycle.
   task automatic load_coeffs(input int n, input logic [31:0] base);
      int got    = 0;
      int pulses = 0;
      int low    = 0;
      int guard  = 0;
      while (!dp_compute && guard < 30) begin
         if (!dp_rstn) low++;
         if (dp_coeff_data_valid) pulses++;
         if (got < n) begin
            s_coeff_tvalid = 1'b1;
            s_coeff_tdata  = base + 32'(got);
            if (s_coeff_tready) got++;
         end else begin
            s_coeff_tvalid = 1'b0;
         end
         tick();
         guard++;
      end
      if (dp_coeff_data_valid) pulses++;
      s_coeff_tvalid = 1'b0;
      check_vec("ld_accepts", 32'(got), 32'(n));
      check_vec("ld_pulses", 32'(pulses), 32'(n));
      check_vec("ld_dprst_low", 32'(low), 32'd1);
      check_vec("ld_compute", 32'(dp_compute), 32'd1);
      check_vec("ld_last_coeff", dp_coeff_data, base + 32'(n - 1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int samp, acc, got, guard, drain_rdy, cyc, next, stalls, nres, extra;
      logic [31:0] exp_val[$];
      int          exp_cyc[$];

      rstn = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_tap_count = '0;
      s_coeff_tvalid = 1'b0; s_coeff_tdata = '0;
      s_data_tvalid = 1'b0; s_data_tdata = '0; m_data_tready = 1'b0;
      warm = 0;
      repeat (3) tick();

      // ---- reset values
      check_vec("rst_busy", 32'(busy), 32'd0);
      check_vec("rst_err", 32'(cfg_error), 32'd0);
      check_vec("rst_coeff_rdy", 32'(s_coeff_tready), 32'd0);
      check_vec("rst_data_rdy", 32'(s_data_tready), 32'd0);
      check_vec("rst_m_valid", 32'(m_data_tvalid), 32'd0);
      check_vec("rst_dprst", 32'(dp_rstn), 32'd0);
      check_vec("rst_compute", 32'(dp_compute), 32'd0);
      check_vec("rst_cvalid", 32'(dp_coeff_data_valid), 32'd0);
      check_vec("rst_ivalid", 32'(dp_input_data_valid), 32'd0);
      check_vec("rst_taps", dp_tap_count, 32'd0);
      check_vec("rst_mdata", m_data_tdata, 32'd0);
      check_vec("rst_cdata", dp_coeff_data, 32'd0);
      check_vec("rst_idata", dp_input_data, 32'd0);
      rstn = 1'b1;
      tick();
      check_vec("idle_dprst", 32'(dp_rstn), 32'd1);

      // ---- illegal tap counts
      start_run(32'd0);
      check_vec("tap0_err", 32'(cfg_error), 32'd1);
      check_vec("tap0_busy", 32'(busy), 32'd0);
      check_vec("tap0_crdy", 32'(s_coeff_tready), 32'd0);
      tick();
      check_vec("tap0_crdy2", 32'(s_coeff_tready), 32'd0);
      start_run(32'd17);
      check_vec("tap17_err", 32'(cfg_error), 32'd1);
      check_vec("tap17_busy", 32'(busy), 32'd0);
      check_vec("tap17_crdy", 32'(s_coeff_tready), 32'd0);
      check_vec("tap17_taps", dp_tap_count, 32'd0);

      // ---- tap count 3, coefficients 1,2,3,4 offered back to back
      cfg_tap_count = 32'd3; cfg_start = 1'b1;
      s_coeff_tvalid = 1'b1; s_coeff_tdata = 32'd1;
      tick();                                   // CLEAR
      cfg_start = 1'b0;
      check_vec("clr_busy", 32'(busy), 32'd1);
      check_vec("clr_err", 32'(cfg_error), 32'd0);
      check_vec("clr_dprst", 32'(dp_rstn), 32'd0);
      check_vec("clr_crdy", 32'(s_coeff_tready), 32'd0);
      check_vec("clr_taps", dp_tap_count, 32'd3);
      tick();                                   // LOAD_COEFF, first handshake
      check_vec("ld_dprst", 32'(dp_rstn), 32'd1);
      check_vec("ld_crdy", 32'(s_coeff_tready), 32'd1);
      check_vec("ld_cvalid0", 32'(dp_coeff_data_valid), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check_vec("ld_cvalid", 32'(dp_coeff_data_valid), 32'd1);
         check_vec("ld_cdata", dp_coeff_data, 32'(k));
         check_vec("ld_crdy_k", 32'(s_coeff_tready), (k < 3) ? 32'd1 : 32'd0);
         check_vec("ld_compute_k", 32'(dp_compute), (k < 3) ? 32'd0 : 32'd1);
         s_coeff_tdata = 32'(k + 1);
      end
      tick();
      check_vec("run_cvalid", 32'(dp_coeff_data_valid), 32'd0);
      check_vec("run_crdy", 32'(s_coeff_tready), 32'd0);
      check_vec("run_compute", 32'(dp_compute), 32'd1);
      s_coeff_tvalid = 1'b0;

      // ---- backpressure: 4 samples fill the credits
      m_data_tready = 1'b0; samp = 10; acc = 0;
      for (int k = 0; k < 8; k++) begin
         s_data_tvalid = 1'b1;
         s_data_tdata  = 32'(samp);
         if (s_data_tready) begin acc++; samp++; end
         tick();
         if (m_data_tvalid) check_vec("bp_hold", m_data_tdata, 32'd37);
      end
      s_data_tvalid = 1'b0;
      check_vec("bp_accepts", 32'(acc), 32'd4);
      check_vec("bp_drdy", 32'(s_data_tready), 32'd0);
      check_vec("bp_mvalid", 32'(m_data_tvalid), 32'd1);
      m_data_tready = 1'b1; got = 0;
      for (int k = 0; k < 8; k++) begin
         if (m_data_tvalid) begin
            check_vec("bp_result", m_data_tdata, 32'(37 + 3 * got));
            got++;
         end
         tick();
      end
      check_vec("bp_count", 32'(got), 32'd4);
      check_vec("bp_drdy_back", 32'(s_data_tready), 32'd1);

      // ---- stop with 2 buffered and 1 in flight
      m_data_tready = 1'b0; samp = 20; acc = 0; guard = 0;
      while (acc < 3 && guard < 10) begin
         s_data_tvalid = 1'b1;
         s_data_tdata  = 32'(samp);
         if (s_data_tready) begin acc++; samp++; end
         tick();
         guard++;
      end
      s_data_tvalid = 1'b0;
      tick();
      check_vec("stop_accepts", 32'(acc), 32'd3);
      check_vec("stop_mvalid", 32'(m_data_tvalid), 32'd1);
      check_vec("stop_head", m_data_tdata, 32'd67);
      cfg_stop = 1'b1;
      tick();                                   // DRAIN
      cfg_stop = 1'b0;
      check_vec("drain_busy", 32'(busy), 32'd1);
      check_vec("drain_drdy", 32'(s_data_tready), 32'd0);
      s_data_tvalid = 1'b1; s_data_tdata = 32'd99;
      m_data_tready = 1'b1; got = 0; drain_rdy = 0; guard = 0;
      while (busy && guard < 12) begin
         if (s_data_tready) drain_rdy++;
         if (m_data_tvalid) begin
            check_vec("drain_result", m_data_tdata, 32'(67 + 3 * got));
            got++;
         end
         tick();
         guard++;
      end
      s_data_tvalid = 1'b0;
      check_vec("drain_count", 32'(got), 32'd3);
      check_vec("drain_idle", 32'(busy), 32'd0);
      check_vec("drain_noaccept", 32'(drain_rdy), 32'd0);
      check_vec("drain_mvalid", 32'(m_data_tvalid), 32'd0);

      // ---- continuous samples 1..20, two warm-up results
      warm = 2;
      start_run(32'd3);
      load_coeffs(3, 32'd5);
      m_data_tready = 1'b1;
      next = 1; cyc = 0; stalls = 0; nres = 0; extra = 0; acc = 0;
      while (cyc < 40) begin
         if (m_data_tvalid) begin
            if (exp_val.size() == 0) begin
               extra++;
            end else begin
               check_vec("cont_val", m_data_tdata, exp_val.pop_front());
               check_vec("cont_lat", 32'(cyc), 32'(exp_cyc.pop_front()));
               nres++;
            end
         end
         if (next <= 20) begin
            s_data_tvalid = 1'b1;
            s_data_tdata  = 32'(next);
            if (s_data_tready) begin
               acc++;
               if (acc > warm) begin
                  exp_val.push_back(32'(next * 3 + 7));
                  exp_cyc.push_back(cyc + 3);
               end
               next++;
            end else begin
               stalls++;
            end
         end else begin
            s_data_tvalid = 1'b0;
         end
         tick();
         cyc++;
      end
      check_vec("cont_accepts", 32'(acc), 32'd20);
      check_vec("cont_stalls", 32'(stalls), 32'd0);
      check_vec("cont_results", 32'(nres), 32'd18);
      check_vec("cont_extra", 32'(extra), 32'd0);
      check_vec("cont_pending", 32'(exp_val.size()), 32'd0);

      // ---- reset pulse mid-RUN
      s_data_tvalid = 1'b1; s_data_tdata = 32'd100;
      tick();
      tick();
      rstn = 1'b0;
      #1;
      check_vec("arst_busy", 32'(busy), 32'd0);
      check_vec("arst_dprst", 32'(dp_rstn), 32'd0);
      check_vec("arst_drdy", 32'(s_data_tready), 32'd0);
      check_vec("arst_compute", 32'(dp_compute), 32'd0);
      check_vec("arst_ivalid", 32'(dp_input_data_valid), 32'd0);
      check_vec("arst_mvalid", 32'(m_data_tvalid), 32'd0);
      check_vec("arst_taps", dp_tap_count, 32'd0);
      check_vec("arst_idata", dp_input_data, 32'd0);
      s_data_tvalid = 1'b0;
      tick();
      rstn = 1'b1;
      tick();

      // ---- fresh start after reset
      warm = 0;
      start_run(32'd2);
      check_vec("re_taps", dp_tap_count, 32'd2);
      load_coeffs(2, 32'd9);
      s_data_tvalid = 1'b1; s_data_tdata = 32'd5;
      check_vec("re_drdy", 32'(s_data_tready), 32'd1);
      tick();
      s_data_tvalid = 1'b0;
      check_vec("re_ivalid", 32'(dp_input_data_valid), 32'd1);
      check_vec("re_idata", dp_input_data, 32'd5);
      tick();
      tick();
      check_vec("re_mvalid", 32'(m_data_tvalid), 32'd1);
      check_vec("re_mdata", m_data_tdata, 32'd22);
      tick();
      check_vec("re_popped", 32'(m_data_tvalid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
      $finish;
   end

endmodule : tb_fir_stream_controller
`default_nettype wire
